// File: rtl/hpdcache_refill_seq_if.sv
// Refill sequencer bus bundle: command, refill beat stream, data-RAM write port
// and directory write port.
interface hpdcache_refill_seq_if #(
    parameter int unsigned SETS         = 64,
    parameter int unsigned WAYS         = 8,
    parameter int unsigned WORD_WIDTH   = 64,
    parameter int unsigned CL_WORDS     = 8,
    parameter int unsigned ACCESS_WORDS = 4,
    parameter int unsigned TAG_WIDTH    = 20
);
    localparam int unsigned BEATS  = CL_WORDS / ACCESS_WORDS;
    localparam int unsigned SET_W  = $clog2(SETS);
    localparam int unsigned WAY_W  = $clog2(WAYS);
    localparam int unsigned ADDR_W = $clog2(SETS * BEATS);
    localparam int unsigned DATA_W = ACCESS_WORDS * WORD_WIDTH;

    logic                 start_valid_i;
    logic                 start_ready_o;
    logic [SET_W-1:0]     start_set_i;
    logic [WAY_W-1:0]     start_way_i;
    logic [TAG_WIDTH-1:0] start_tag_i;

    logic                 rdata_valid_i;
    logic                 rdata_ready_o;
    logic [DATA_W-1:0]    rdata_i;
    logic                 rdata_error_i;

    logic                 ram_req_o;
    logic                 ram_gnt_i;
    logic [ADDR_W-1:0]    ram_addr_o;
    logic [WAY_W-1:0]     ram_way_o;
    logic [DATA_W-1:0]    ram_wdata_o;

    logic                 dir_we_o;
    logic [SET_W-1:0]     dir_set_o;
    logic [WAY_W-1:0]     dir_way_o;
    logic [TAG_WIDTH-1:0] dir_tag_o;
    logic                 dir_valid_o;

    logic                 busy_o;
    logic                 done_o;

    // Sequencer side
    modport slave (
        input  start_valid_i, start_set_i, start_way_i, start_tag_i,
        input  rdata_valid_i, rdata_i, rdata_error_i, ram_gnt_i,
        output start_ready_o, rdata_ready_o,
        output ram_req_o, ram_addr_o, ram_way_o, ram_wdata_o,
        output dir_we_o, dir_set_o, dir_way_o, dir_tag_o, dir_valid_o,
        output busy_o, done_o
    );

    // Miss handler / arbiter side
    modport master (
        output start_valid_i, start_set_i, start_way_i, start_tag_i,
        output rdata_valid_i, rdata_i, rdata_error_i, ram_gnt_i,
        input  start_ready_o, rdata_ready_o,
        input  ram_req_o, ram_addr_o, ram_way_o, ram_wdata_o,
        input  dir_we_o, dir_set_o, dir_way_o, dir_tag_o, dir_valid_o,
        input  busy_o, done_o
    );
endinterface

// File: rtl/hpdcache_refill_seq.sv
// HPDcache refill sequencer: writes a refilled line beat by beat into the data RAM,
// then issues one directory write that validates or invalidates the line.
module hpdcache_refill_seq #(
    parameter int unsigned SETS         = 64,
    parameter int unsigned WAYS         = 8,
    parameter int unsigned WORD_WIDTH   = 64,
    parameter int unsigned CL_WORDS     = 8,
    parameter int unsigned ACCESS_WORDS = 4,
    parameter int unsigned TAG_WIDTH    = 20
) (
    input logic                  clk_i,
    input logic                  rst_ni,
    hpdcache_refill_seq_if.slave bus
);
    localparam int unsigned BEATS  = CL_WORDS / ACCESS_WORDS;
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned SET_W  = $clog2(SETS);
    localparam int unsigned WAY_W  = $clog2(WAYS);
    localparam int unsigned ADDR_W = $clog2(SETS * BEATS);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DATA = 2'd1;
    localparam logic [1:0] ST_DIR  = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [SET_W-1:0]     set_q, set_d;
    logic [WAY_W-1:0]     way_q, way_d;
    logic [TAG_WIDTH-1:0] tag_q, tag_d;
    logic [BEAT_W-1:0]    beat_q, beat_d;
    logic                 err_q, err_d;

    logic start_ready_c, rdata_ready_c, ram_req_c, dir_we_c, busy_c;

    // State and refill context registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            set_q   <= '0;
            way_q   <= '0;
            tag_q   <= '0;
            beat_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            set_q   <= set_d;
            way_q   <= way_d;
            tag_q   <= tag_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
        end
    end

    // Next-state and handshake decode
    always_comb begin
        state_d       = state_q;
        set_d         = set_q;
        way_d         = way_q;
        tag_d         = tag_q;
        beat_d        = beat_q;
        err_d         = err_q;
        start_ready_c = 1'b0;
        rdata_ready_c = 1'b0;
        ram_req_c     = 1'b0;
        dir_we_c      = 1'b0;
        busy_c        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                start_ready_c = 1'b1;
                if (bus.start_valid_i) begin
                    set_d   = bus.start_set_i;
                    way_d   = bus.start_way_i;
                    tag_d   = bus.start_tag_i;
                    beat_d  = '0;
                    err_d   = 1'b0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                busy_c        = 1'b1;
                ram_req_c     = bus.rdata_valid_i;
                rdata_ready_c = bus.rdata_valid_i & bus.ram_gnt_i;
                if (rdata_ready_c) begin
                    err_d = err_q | bus.rdata_error_i;
                    // Hold beat_q on the last beat so the counter never wraps mid-refill
                    if (beat_q == BEAT_W'(BEATS - 1)) begin
                        state_d = ST_DIR;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            ST_DIR: begin
                busy_c   = 1'b1;
                dir_we_c = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.start_ready_o = start_ready_c;
    assign bus.rdata_ready_o = rdata_ready_c;
    assign bus.ram_req_o     = ram_req_c;
    assign bus.ram_addr_o    = ADDR_W'(set_q) * ADDR_W'(BEATS) + ADDR_W'(beat_q);
    assign bus.ram_way_o     = way_q;
    assign bus.ram_wdata_o   = bus.rdata_i;
    assign bus.dir_we_o      = dir_we_c;
    assign bus.dir_set_o     = set_q;
    assign bus.dir_way_o     = way_q;
    assign bus.dir_tag_o     = tag_q;
    assign bus.dir_valid_o   = ~err_q;
    assign bus.busy_o        = busy_c;
    assign bus.done_o        = dir_we_c;
endmodule

// File: doc/hpdcache_refill_seq.md
# hpdcache_refill_seq

Refill sequencer for the HPDcache data and directory memories. It accepts a refill command (set, way, tag) from the miss handler and consumes the refill data stream, one ACCESS_WORDS-wide beat at a time. Each beat is written into the data RAM through a request/grant handshake with the data-RAM port arbiter. After the last beat it issues a single directory write that validates or invalidates the refilled line. It sits between the miss-handler refill FIFO and the data/directory RAM arbiters.

## Interface

Parameters:
- SETS, 64: cache sets; power of two.
- WAYS, 8: cache ways; power of two.
- WORD_WIDTH, 64: data word width in bits.
- CL_WORDS, 8: words per cache line.
- ACCESS_WORDS, 4: words per beat; must divide CL_WORDS.
- TAG_WIDTH, 20: directory tag width.

Derived (localparams):
- BEATS = CL_WORDS/ACCESS_WORDS.
- BEAT_W = max(1, clog2(BEATS)).
- ADDR_W = clog2(SETS*BEATS).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- start_valid_i  in  1  refill command valid.
- start_ready_o  out  1  command accepted; high only in IDLE.
- start_set_i  in  clog2(SETS)  target set.
- start_way_i  in  clog2(WAYS)  target way (binary index).
- start_tag_i  in  TAG_WIDTH  tag of the refilled line.
- rdata_valid_i  in  1  refill beat valid.
- rdata_ready_o  out  1  beat consumed.
- rdata_i  in  ACCESS_WORDS*WORD_WIDTH  beat data; word 0 in the LSBs.
- rdata_error_i  in  1  memory error flag for this beat.
- ram_req_o  out  1  data-RAM write request.
- ram_gnt_i  in  1  grant; same-cycle, combinational from ram_req_o permitted.
- ram_addr_o  out  ADDR_W  data-RAM row = set*BEATS + beat.
- ram_way_o  out  clog2(WAYS)  way written.
- ram_wdata_o  out  ACCESS_WORDS*WORD_WIDTH  write data.
- dir_we_o  out  1  directory write strobe, one cycle.
- dir_set_o  out  clog2(SETS)  directory set.
- dir_way_o  out  clog2(WAYS)  directory way.
- dir_tag_o  out  TAG_WIDTH  directory tag.
- dir_valid_o  out  1  valid bit written; 0 if any beat reported an error.
- busy_o  out  1  high in DATA or DIR.
- done_o  out  1  one-cycle pulse, coincident with dir_we_o.

## Operation

- FSM states: IDLE, DATA, DIR.
- IDLE: start_ready_o=1.
  - On start_valid_i, capture set, way and tag; clear beat_q and err_q; go to DATA.
- DATA: ram_req_o = rdata_valid_i; rdata_ready_o = rdata_valid_i & ram_gnt_i.
  - A beat is written when rdata_valid_i & ram_gnt_i.
  - On a write, beat_q increments and err_q |= rdata_error_i.
  - On the write where beat_q == BEATS-1, go to DIR.
- ram_wdata_o = rdata_i, combinational.
- ram_addr_o = {set_q, beat_q}; ram_way_o = way_q.
- Erroneous beats are still written to the data RAM; only the directory valid bit reflects the error.
- A valid beat without a grant is held. The sequencer keeps ram_req_o asserted and does not pop the beat.
- DIR: dir_we_o=1, done_o=1, dir_valid_o = ~err_q, with the captured set/way/tag. Go to IDLE unconditionally.
  - The directory write has no handshake; the directory arbiter gives refill absolute priority.
- rdata_ready_o=0 outside DATA, so beats arriving early stay in the upstream FIFO.
- Outside DATA, ram_req_o=0. Outside DIR, dir_we_o=0 and done_o=0.
- Reset (asynchronous, any state): FSM→IDLE, beat_q=0, err_q=0, set_q/way_q/tag_q=0. No directory write is issued for an aborted refill.
- Reset values of outputs:
  - start_ready_o=1.
  - rdata_ready_o=0, ram_req_o=0.
  - dir_we_o=0, done_o=0, busy_o=0.
  - dir_valid_o=1 (err_q=0).
  - ram_addr_o=0, dir_* buses=0.

## Timing

- Command accepted at cycle 0; DATA starts at cycle 1.
- With rdata_valid_i and ram_gnt_i held high, beats are written in cycles 1..BEATS.
- dir_we_o/done_o fire at cycle BEATS+1.
- start_ready_o is high again at cycle BEATS+2.
- Minimum start-to-start spacing is BEATS+2 cycles. There is no back-to-back overlap.
- Each cycle with grant low, or valid low, in DATA adds exactly one cycle of latency.
- beat_q does not wrap within a refill; it resets to 0 on the next accepted start.

## Test plan

- Default parameters, start set=5, way=3, tag=0xABCDE; 2 beats, valid and grant held high.
  - Writes at addr 10 then 11, way 3.
  - dir_we_o at cycle 3 with set 5, way 3, tag 0xABCDE, valid 1.
  - start_ready_o high at cycle 4.
- Same refill with ram_gnt_i low for 3 cycles on beat 0.
  - ram_req_o held; rdata_ready_o=0 and ram_addr_o=10 stable for those 3 cycles.
  - dir_we_o at cycle 6.
- rdata_error_i=1 on beat 1 only.
  - Both beats written.
  - dir_valid_o=0. The next refill, error-free, gives dir_valid_o=1.
- rdata_valid_i high while in IDLE and during a start cycle.
  - rdata_ready_o=0 and no ram_req_o until DATA.
- Assert rst_ni low after beat 0 of a refill.
  - All outputs at their reset values immediately.
  - No dir_we_o after release; a new start for set 63 writes addr 126 then 127.
- CL_WORDS=8, ACCESS_WORDS=1 (BEATS=8), set 1.
  - Addresses 8..15 in order.
  - done_o one cycle at cycle 9, concurrent with dir_we_o.
